// File: rtl/cam_cfg_seq.sv
// Power-up camera register sequencer: walks a write ROM and hands each word to the I2C engine.
// Optional ack watchdog with retries is enabled by defining CAM_CFG_TIMEOUT_EN.
module cam_cfg_seq #(
  parameter logic [15:0] LUT_SIZE     = 16'd256,
  parameter logic [15:0] PWRUP_CYCLES = 16'd4000
`ifdef CAM_CFG_TIMEOUT_EN
  ,
  parameter logic [7:0]  TIMEOUT      = 8'd64,
  parameter logic [1:0]  MAX_RETRY    = 2'd3
`endif
) (
  input  logic        clk_20k,
  input  logic        rst_100,
  input  logic        start,
  input  logic        i2c_ack,
  output logic [31:0] cfg_data,
  output logic        i2c_req,
  output logic [15:0] cfg_index,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_err
);

  typedef enum logic [2:0] {
    PWRUP, LOAD, REQ_LOW, REQ_HIGH, DELAY, NEXT, DONE
  } state_t;

  state_t      state;
  logic [15:0] cnt;
  logic [31:0] rom_word;
  logic [15:0] dly_last;

`ifdef CAM_CFG_TIMEOUT_EN
  logic [7:0]  wdog;
  logic [1:0]  retry;
`else
  assign cfg_err = 1'b0;
`endif

  // Write words are {dev_addr, reg_addr, data}; dev_addr 8'hFF marks a wait of data[15:0] cycles.
  always_comb begin
    rom_word = 32'hFF00_0000;
    case (cfg_index)
      16'd0:   rom_word = 32'h7830_0882;
      16'd1:   rom_word = 32'hFF00_0FA0;
      16'd2:   rom_word = 32'h7830_0842;
      default: rom_word = 32'hFF00_0000;
    endcase
  end

  // A zero-length wait still occupies one DELAY cycle.
  assign dly_last = (cfg_data[15:0] == 16'd0) ? 16'd0 : cfg_data[15:0] - 16'd1;

  always_ff @(posedge clk_20k or negedge rst_100) begin
    if (!rst_100) begin
      state     <= PWRUP;
      cnt       <= 16'd0;
      cfg_data  <= 32'd0;
      i2c_req   <= 1'b0;
      cfg_index <= 16'd0;
      cfg_busy  <= 1'b1;
      cfg_done  <= 1'b0;
`ifdef CAM_CFG_TIMEOUT_EN
      cfg_err   <= 1'b0;
      wdog      <= 8'd0;
      retry     <= 2'd0;
`endif
    end else if (start) begin
      // Restart abandons any write in flight; dropping req re-arms the engine.
      state     <= PWRUP;
      cnt       <= 16'd0;
      i2c_req   <= 1'b0;
      cfg_index <= 16'd0;
      cfg_busy  <= 1'b1;
      cfg_done  <= 1'b0;
`ifdef CAM_CFG_TIMEOUT_EN
      cfg_err   <= 1'b0;
      wdog      <= 8'd0;
      retry     <= 2'd0;
`endif
    end else begin
      case (state)
        PWRUP: begin
          if (cnt == PWRUP_CYCLES - 16'd1) begin
            cnt   <= 16'd0;
            state <= LOAD;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        LOAD: begin
          cfg_data <= rom_word;
          cnt      <= 16'd0;
`ifdef CAM_CFG_TIMEOUT_EN
          retry    <= 2'd0;
`endif
          state    <= (rom_word[31:24] == 8'hFF) ? DELAY : REQ_LOW;
        end
        REQ_LOW: begin
          // Two low cycles clear the engine's bit counter and any stale ack.
          if (cnt == 16'd1) begin
            cnt     <= 16'd0;
            i2c_req <= 1'b1;
`ifdef CAM_CFG_TIMEOUT_EN
            wdog    <= 8'd0;
`endif
            state   <= REQ_HIGH;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        REQ_HIGH: begin
          if (i2c_ack) begin
            i2c_req <= 1'b0;
            state   <= NEXT;
          end
`ifdef CAM_CFG_TIMEOUT_EN
          else if (wdog == TIMEOUT - 8'd1) begin
            i2c_req <= 1'b0;
            wdog    <= 8'd0;
            if (retry == MAX_RETRY) begin
              cfg_err <= 1'b1;
              state   <= NEXT;
            end else begin
              retry <= retry + 2'd1;
              cnt   <= 16'd0;
              state <= REQ_LOW;
            end
          end else begin
            wdog <= wdog + 8'd1;
          end
`endif
        end
        DELAY: begin
          if (cnt == dly_last) begin
            cnt   <= 16'd0;
            state <= NEXT;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        NEXT: begin
          i2c_req <= 1'b0;
          if (cfg_index == LUT_SIZE - 16'd1) begin
            cfg_busy <= 1'b0;
            cfg_done <= 1'b1;
            state    <= DONE;
          end else begin
            cfg_index <= cfg_index + 16'd1;
            state     <= LOAD;
          end
        end
        DONE: begin
          i2c_req  <= 1'b0;
          cfg_busy <= 1'b0;
          cfg_done <= 1'b1;
        end
        default: state <= PWRUP;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_cfg_seq.sv
// Directed bench for cam_cfg_seq with LUT_SIZE=4, PWRUP_CYCLES=10 and an I2C engine model
// that raises ack 42 cycles after req rises (stall forces ack low).
module tb_cam_cfg_seq;
  logic        clk_20k = 1'b0;
  logic        rst_100 = 1'b0;
  logic        start = 1'b0;
  logic        i2c_ack;
  logic        stall = 1'b0;
  logic [31:0] cfg_data;
  logic        i2c_req;
  logic [15:0] cfg_index;
  logic        cfg_busy;
  logic        cfg_done;
  logic        cfg_err;
  logic [7:0]  ecnt;
  int          checks = 0;
  int          errors = 0;

  always #5 clk_20k = ~clk_20k;

  cam_cfg_seq #(.LUT_SIZE(16'd4), .PWRUP_CYCLES(16'd10)) dut (
    .clk_20k(clk_20k), .rst_100(rst_100), .start(start), .i2c_ack(i2c_ack),
    .cfg_data(cfg_data), .i2c_req(i2c_req), .cfg_index(cfg_index),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err)
  );

  // Engine model: ack goes high 42 edges after req rises, clears when req drops.
  always @(posedge clk_20k or negedge rst_100) begin
    if (!rst_100) begin
      ecnt <= 8'd0; i2c_ack <= 1'b0;
    end else if (!i2c_req || stall) begin
      ecnt <= 8'd0; i2c_ack <= 1'b0;
    end else if (ecnt == 8'd41) begin
      i2c_ack <= 1'b1;
    end else begin
      ecnt <= ecnt + 8'd1;
    end
  end

  task automatic test_reset();
    rst_100 = 1'b0;
    repeat (3) @(negedge clk_20k);
    checks++; if (cfg_data !== 32'd0) begin errors++; $display("FAIL rst_data got %h exp 0", cfg_data); end
    checks++; if (i2c_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", i2c_req); end
    checks++; if (cfg_index !== 16'd0) begin errors++; $display("FAIL rst_index got %0d exp 0", cfg_index); end
    checks++; if (cfg_busy !== 1'b1) begin errors++; $display("FAIL rst_busy got %b exp 1", cfg_busy); end
    checks++; if (cfg_done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", cfg_done); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", cfg_err); end
  endtask

  task automatic test_pwrup();
    rst_100 = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      @(negedge clk_20k);
      if (i <= 12) begin
        checks++; if (i2c_req !== 1'b0) begin errors++; $display("FAIL pwrup_req_low cyc %0d got %b exp 0", i, i2c_req); end
      end
      if (i == 10) begin
        checks++; if (cfg_data !== 32'd0) begin errors++; $display("FAIL pwrup_data_early got %h exp 0", cfg_data); end
      end
      if (i == 11) begin
        checks++; if (cfg_data !== 32'h7830_0882) begin errors++; $display("FAIL load_data got %h exp 78300882", cfg_data); end
      end
    end
    checks++; if (i2c_req !== 1'b1) begin errors++; $display("FAIL req_rise got %b exp 1", i2c_req); end
    checks++; if (cfg_busy !== 1'b1) begin errors++; $display("FAIL pwrup_busy got %b exp 1", cfg_busy); end
  endtask

  task automatic test_handshake();
    int n = 0;
    int bad = 0;
    while (i2c_req === 1'b1 && n < 100) begin
      if (cfg_data !== 32'h7830_0882) bad++;
      n++;
      @(negedge clk_20k);
    end
    checks++; if (n != 43) begin errors++; $display("FAIL req_high_len got %0d exp 43", n); end
    checks++; if (bad != 0) begin errors++; $display("FAIL data_stable got %0d bad exp 0", bad); end
    checks++; if (cfg_index !== 16'd0) begin errors++; $display("FAIL index_at_next got %0d exp 0", cfg_index); end
    @(negedge clk_20k);
    checks++; if (cfg_index !== 16'd1) begin errors++; $display("FAIL index_adv got %0d exp 1", cfg_index); end
  endtask

  task automatic test_delay();
    int n = 0;
    bit saw_req = 1'b0;
    while (cfg_index === 16'd1 && n < 5000) begin
      if (i2c_req) saw_req = 1'b1;
      @(negedge clk_20k);
      n++;
    end
    checks++; if (n != 4002) begin errors++; $display("FAIL delay_len got %0d exp 4002", n); end
    checks++; if (saw_req !== 1'b0) begin errors++; $display("FAIL delay_req got %b exp 0", saw_req); end
    checks++; if (cfg_index !== 16'd2) begin errors++; $display("FAIL delay_index got %0d exp 2", cfg_index); end
    @(negedge clk_20k);
    checks++; if (cfg_data !== 32'h7830_0842) begin errors++; $display("FAIL entry2_data got %h exp 78300842", cfg_data); end
  endtask

  task automatic test_end_of_table();
    int n = 0;
    int changed = 0;
    bit saw_req = 1'b0;
    while (cfg_done !== 1'b1 && n < 300) begin
      if (i2c_req) saw_req = 1'b1;
      @(negedge clk_20k);
      n++;
    end
    checks++; if (cfg_done !== 1'b1) begin errors++; $display("FAIL done_set got %b exp 1", cfg_done); end
    checks++; if (saw_req !== 1'b1) begin errors++; $display("FAIL entry2_write got %b exp 1", saw_req); end
    checks++; if (cfg_busy !== 1'b0) begin errors++; $display("FAIL done_busy got %b exp 0", cfg_busy); end
    checks++; if (cfg_index !== 16'd3) begin errors++; $display("FAIL done_index got %0d exp 3", cfg_index); end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_20k);
      if (cfg_done !== 1'b1 || cfg_busy !== 1'b0 || i2c_req !== 1'b0 || cfg_index !== 16'd3) changed++;
    end
    checks++; if (changed != 0) begin errors++; $display("FAIL done_hold got %0d changes exp 0", changed); end
  endtask

  task automatic test_start_restart();
    int n;
    start = 1'b1;
    @(negedge clk_20k);
    start = 1'b0;
    checks++; if (cfg_done !== 1'b0 || cfg_busy !== 1'b1 || cfg_index !== 16'd0)
      begin errors++; $display("FAIL start_from_done got done=%b busy=%b idx=%0d exp 0/1/0", cfg_done, cfg_busy, cfg_index); end
    n = 0;
    while (i2c_req !== 1'b1 && n < 50) begin @(negedge clk_20k); n++; end
    checks++; if (n != 13) begin errors++; $display("FAIL restart_pwrup got %0d exp 13", n); end
    n = 0;
    while (!(cfg_index === 16'd2 && i2c_req === 1'b1) && n < 6000) begin @(negedge clk_20k); n++; end
    checks++; if (cfg_index !== 16'd2 || i2c_req !== 1'b1)
      begin errors++; $display("FAIL reach_idx2 got idx=%0d req=%b exp 2/1", cfg_index, i2c_req); end
    repeat (5) @(negedge clk_20k);
    start = 1'b1;
    @(negedge clk_20k);
    start = 1'b0;
    checks++; if (i2c_req !== 1'b0) begin errors++; $display("FAIL abort_req got %b exp 0", i2c_req); end
    checks++; if (cfg_index !== 16'd0) begin errors++; $display("FAIL abort_index got %0d exp 0", cfg_index); end
    checks++; if (cfg_done !== 1'b0 || cfg_busy !== 1'b1)
      begin errors++; $display("FAIL abort_flags got done=%b busy=%b exp 0/1", cfg_done, cfg_busy); end
    n = 0;
    while (i2c_req !== 1'b1 && n < 50) begin @(negedge clk_20k); n++; end
    checks++; if (n != 13) begin errors++; $display("FAIL abort_pwrup got %0d exp 13", n); end
    checks++; if (cfg_data !== 32'h7830_0882) begin errors++; $display("FAIL abort_data got %h exp 78300882", cfg_data); end
  endtask

  task automatic test_async_reset();
    repeat (3) @(negedge clk_20k);
    #2 rst_100 = 1'b0;
    #1;
    checks++; if (i2c_req !== 1'b0 || cfg_data !== 32'd0 || cfg_index !== 16'd0 || cfg_busy !== 1'b1 || cfg_done !== 1'b0)
      begin errors++; $display("FAIL async_rst got req=%b data=%h idx=%0d busy=%b done=%b exp 0/0/0/1/0",
                               i2c_req, cfg_data, cfg_index, cfg_busy, cfg_done); end
    @(negedge clk_20k);
  endtask

  task automatic test_timeout();
    int n;
    stall = 1'b1;
    rst_100 = 1'b1;
`ifdef CAM_CFG_TIMEOUT_EN
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (i2c_req !== 1'b1 && n < 100) begin @(negedge clk_20k); n++; end
      n = 0;
      while (i2c_req === 1'b1 && n < 200) begin @(negedge clk_20k); n++; end
      checks++; if (n != 64) begin errors++; $display("FAIL tmo_len send %0d got %0d exp 64", k, n); end
      checks++; if (cfg_err !== (k == 3)) begin errors++; $display("FAIL tmo_err send %0d got %b exp %b", k, cfg_err, (k == 3)); end
    end
    checks++; if (cfg_index !== 16'd0) begin errors++; $display("FAIL tmo_idx_hold got %0d exp 0", cfg_index); end
    @(negedge clk_20k);
    checks++; if (cfg_index !== 16'd1) begin errors++; $display("FAIL tmo_skip got %0d exp 1", cfg_index); end
`else
    n = 0;
    while (i2c_req !== 1'b1 && n < 50) begin @(negedge clk_20k); n++; end
    n = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk_20k);
      if (i2c_req !== 1'b1 || cfg_err !== 1'b0 || cfg_index !== 16'd0) n++;
    end
    checks++; if (n != 0) begin errors++; $display("FAIL stuck_wait got %0d bad cycles exp 0", n); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL stuck_err got %b exp 0", cfg_err); end
`endif
    stall = 1'b0;
  endtask

  initial begin
    test_reset();
    test_pwrup();
    test_handshake();
    test_delay();
    test_end_of_table();
    test_start_restart();
    test_async_reset();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
